bus_fabric_n: RTL



---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_rd_tracker.sv | 33 +++
 rtl/bus_fabric_n.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the register-bus fabric.
package bus_pkg;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    // Widest slave-select field any fabric instance may use (up to 16 slaves).
    localparam int MAX_SEL_W = 4;

    localparam logic [15:0] ERR_RD_DATA_DEF = 16'hDEAD;

    // One in-flight read slot. idx is sized for the widest select field so
    // the same entry type serves every fabric configuration.
    typedef struct packed {
        logic                 rd;
        logic                 mapped;
        logic [MAX_SEL_W-1:0] idx;
    } trk_entry_t;

    localparam int TRK_W = $bits(trk_entry_t);

endpackage

// File: rtl/bus_rd_tracker.sv
// Fixed-depth shift pipeline that follows each command until its slave
// read data is due. A slot enters on every cycle, so the tail always
// corresponds to the command issued DEPTH cycles earlier.
module bus_rd_tracker
    import bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TRK_W-1:0] entry_in,
    output logic [TRK_W-1:0] entry_out
);

    logic [TRK_W-1:0] stage_reg [DEPTH];

    // Shift one slot per cycle; reset flushes every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= entry_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign entry_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/bus_fabric_n.sv
// Master-to-N-slave register bus fabric: registered command decode,
// fixed-latency in-order read return, unmapped-access error counting.
module bus_fabric_n
    import bus_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                NUM_SLV     = 3,
    parameter int                SEL_W       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
    parameter int                SLV_RD_LAT  = 1,
    parameter logic [DATA_W-1:0] ERR_RD_DATA = ERR_RD_DATA_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_cmd_valid,
    input  logic                      bus_op,
    input  logic [ADDR_W-1:0]         bus_addr,
    input  logic [DATA_W-1:0]         bus_wr_data,
    output logic [DATA_W-1:0]         bus_rd_data,
    output logic                      bus_rd_valid,
    output logic [NUM_SLV-1:0]        slv_cmd_valid,
    output logic                      slv_op,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wr_data,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rd_data,
    input  logic                      err_clr,
    output logic [7:0]                err_cnt,
    output logic                      err_flag
);

    localparam int TRK_DEPTH = SLV_RD_LAT + 1;
    localparam int NUM_IDX   = 1 << MAX_SEL_W;
    // Upper SEL_W address bits pick the slave; slaves see them as zero.
    localparam logic [ADDR_W-1:0] SEL_MASK = ~({ADDR_W{1'b1}} >> SEL_W);

    logic [SEL_W-1:0]   cmd_idx;
    logic               cmd_mapped;
    logic [NUM_SLV-1:0] dec_hit;
    logic [DATA_W-1:0]  slv_rd_arr [NUM_IDX];
    trk_entry_t         trk_in;
    trk_entry_t         trk_tail;

    logic [NUM_SLV-1:0] slv_cmd_valid_reg;
    logic               slv_op_reg;
    logic [ADDR_W-1:0]  slv_addr_reg;
    logic [DATA_W-1:0]  slv_wr_data_reg;
    logic [DATA_W-1:0]  bus_rd_data_reg;
    logic               bus_rd_valid_reg;
    logic [7:0]         err_cnt_reg;
    logic [7:0]         err_cnt_next;
    logic               err_flag_reg;
    logic               err_flag_next;

    assign cmd_idx    = bus_addr[ADDR_W-1 -: SEL_W];
    assign cmd_mapped = (int'(cmd_idx) < NUM_SLV);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_dec
            assign dec_hit[gi] = bus_cmd_valid && cmd_mapped && (int'(cmd_idx) == gi);
        end
        // Unused return slots read as the error word so the mux never
        // indexes past the populated slaves.
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_rd
            if (gi < NUM_SLV) begin : g_map
                assign slv_rd_arr[gi] = slv_rd_data[gi*DATA_W +: DATA_W];
            end else begin : g_unmap
                assign slv_rd_arr[gi] = ERR_RD_DATA;
            end
        end
    endgenerate

    // Build the tracker slot for this cycle; idle cycles enter rd=0.
    always_comb begin
        trk_in                  = '0;
        trk_in.rd               = bus_cmd_valid && (bus_op == BUS_RD);
        trk_in.mapped           = cmd_mapped;
        trk_in.idx[SEL_W-1:0]   = cmd_idx;
    end

    bus_rd_tracker #(
        .DEPTH     (TRK_DEPTH)
    ) u_rd_tracker (
        .clk       (clk),
        .rst       (rst),
        .entry_in  (trk_in),
        .entry_out (trk_tail)
    );

    // Register the command toward the slaves; broadcast fields hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            slv_cmd_valid_reg <= '0;
            slv_op_reg        <= 1'b0;
            slv_addr_reg      <= '0;
            slv_wr_data_reg   <= '0;
        end else begin
            slv_cmd_valid_reg <= dec_hit;
            if (bus_cmd_valid) begin
                slv_op_reg      <= bus_op;
                slv_addr_reg    <= bus_addr & ~SEL_MASK;
                slv_wr_data_reg <= bus_wr_data;
            end
        end
    end

    // Capture slave (or error) data when a read slot reaches the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rd_valid_reg <= 1'b0;
            bus_rd_data_reg  <= '0;
        end else begin
            bus_rd_valid_reg <= trk_tail.rd;
            if (trk_tail.rd) begin
                bus_rd_data_reg <= trk_tail.mapped ? slv_rd_arr[trk_tail.idx] : ERR_RD_DATA;
            end
        end
    end

    // Clear takes effect first, then a same-cycle unmapped access counts.
    always_comb begin
        err_cnt_next  = err_clr ? 8'd0 : err_cnt_reg;
        err_flag_next = err_clr ? 1'b0 : err_flag_reg;
        if (bus_cmd_valid && !cmd_mapped) begin
            if (err_cnt_next != 8'hFF) begin
                err_cnt_next = err_cnt_next + 8'd1;
            end
            err_flag_next = 1'b1;
        end
    end

    // Error counter and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg  <= '0;
            err_flag_reg <= 1'b0;
        end else begin
            err_cnt_reg  <= err_cnt_next;
            err_flag_reg <= err_flag_next;
        end
    end

    assign slv_cmd_valid = slv_cmd_valid_reg;
    assign slv_op        = slv_op_reg;
    assign slv_addr      = slv_addr_reg;
    assign slv_wr_data   = slv_wr_data_reg;
    assign bus_rd_data   = bus_rd_data_reg;
    assign bus_rd_valid  = bus_rd_valid_reg;
    assign err_cnt       = err_cnt_reg;
    assign err_flag      = err_flag_reg;

endmodule
